// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
//   Avalon-MM slave that steps the compute units through NUM_LAYERS layers.
//   Each layer pulses start_out to every unit in UNIT_MASK, then waits until
//   every masked unit has produced a rising edge on done_in. The host polls
//   one STATUS register, or takes a level interrupt, instead of polling each
//   unit separately.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   address[2:0]        word address
//   write, writedata    write strobe and data
//   readdata[31:0]      registered read data (1-cycle latency, every clk)
//   start_out[NU-1:0]   one-cycle start pulse per unit
//   done_in[NU-1:0]     unit done levels (same clock domain)
//   irq                 complete & irq_en
//
// Register map
//   0 CTRL      W : bit0 go, bit1 abort, bit2 irq_en (reads 0)
//   1 STATUS    R : bit0 busy, bit1 complete (W1C), bit2 irq_en
//   2 NUM_LAYERS RW, 3 UNIT_MASK RW, 4 LAYER_IDX RO, 5 DONE_CAP RO

module nn_layer_sequencer #(
    parameter int NUM_UNITS = 4,
    parameter int LAYER_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [NUM_UNITS-1:0] start_out,
    input  logic [NUM_UNITS-1:0] done_in,
    output logic                 irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LAYER_W-1:0]   r_num_layers;
    logic [LAYER_W-1:0]   r_layer_idx;
    logic [NUM_UNITS-1:0] r_unit_mask;
    logic [NUM_UNITS-1:0] r_done_cap;
    logic [NUM_UNITS-1:0] r_done_prev;
    logic                 r_complete;
    logic                 r_irq_en;
    logic [31:0]          r_readdata;

    logic                 w_busy;
    logic                 w_wr_ctrl;
    logic                 w_go;
    logic                 w_abort;
    logic                 w_launch;
    logic [NUM_UNITS-1:0] w_rise;
    logic [LAYER_W-1:0]   w_idx_inc;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_busy    = (r_state != S_IDLE);
    assign w_wr_ctrl = write && (address == 3'd0);
    assign w_go      = w_wr_ctrl && writedata[0];
    assign w_abort   = w_wr_ctrl && writedata[1];
    // go only launches from IDLE, and abort in the same write suppresses it
    assign w_launch  = (r_state == S_IDLE) && w_go && !w_abort;
    // Edge detect so a done level left high from the previous layer is not
    // mistaken for completion of the current one.
    assign w_rise    = done_in & ~r_done_prev & r_unit_mask;
    assign w_idx_inc = r_layer_idx + LAYER_W'(1);
    assign w_unused  = ^writedata;

    assign start_out = (r_state == S_START) ? r_unit_mask : '0;
    assign irq       = r_complete & r_irq_en;
    assign readdata  = r_readdata;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_launch)
                          w_state_nxt = (r_num_layers == '0) ? S_FINISH : S_START;
            S_START:  w_state_nxt = S_WAIT;
            S_WAIT:   if ((r_done_cap & r_unit_mask) == r_unit_mask)
                          w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = (w_idx_inc == r_num_layers) ? S_FINISH : S_START;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort && w_busy)
            w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            3'd1: w_rdata[2:0]           = {r_irq_en, r_complete, w_busy};
            3'd2: w_rdata[LAYER_W-1:0]   = r_num_layers;
            3'd3: w_rdata[NUM_UNITS-1:0] = r_unit_mask;
            3'd4: w_rdata[LAYER_W-1:0]   = r_layer_idx;
            3'd5: w_rdata[NUM_UNITS-1:0] = r_done_cap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_num_layers <= '0;
            r_layer_idx  <= '0;
            r_unit_mask  <= '0;
            r_done_cap   <= '0;
            r_done_prev  <= '0;
            r_complete   <= 1'b0;
            r_irq_en     <= 1'b0;
            r_readdata   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_prev <= done_in;
            r_readdata  <= w_rdata;

            if (w_wr_ctrl)
                r_irq_en <= writedata[2];
            if (write && (address == 3'd2) && !w_busy)
                r_num_layers <= writedata[LAYER_W-1:0];
            if (write && (address == 3'd3) && !w_busy)
                r_unit_mask <= writedata[NUM_UNITS-1:0];

            // FINISH set takes priority over a same-cycle W1C clear
            if ((r_state == S_FINISH) && !w_abort)
                r_complete <= 1'b1;
            else if (write && (address == 3'd1) && writedata[1])
                r_complete <= 1'b0;

            // On abort, LAYER_IDX and DONE_CAP freeze for post-mortem reads
            if (w_launch) begin
                r_layer_idx <= '0;
                r_done_cap  <= '0;
            end else if (!w_abort) begin
                if ((r_state == S_START) || (r_state == S_WAIT))
                    r_done_cap <= r_done_cap | w_rise;
                if (r_state == S_NEXT) begin
                    r_layer_idx <= w_idx_inc;
                    r_done_cap  <= '0;
                end
            end
        end
    end

endmodule
